// File: rtl/muntjac_fpu_round_pack.sv
// Rounding-mode encoding shared by the FPU datapath, and the two-stage round/pack
// pipeline that turns an unpacked {sign, exponent, significand} into an IEEE word.
package muntjac_fpu_pkg;

    typedef enum logic [2:0] {
        RoundTiesToEven     = 3'b000,
        RoundTowardZero     = 3'b001,
        RoundTowardNegative = 3'b010,
        RoundTowardPositive = 3'b011,
        RoundTiesToAway     = 3'b100
    } rounding_mode_e;

endpackage

module muntjac_fpu_round_pack #(
    parameter int InExpWidth = 10,
    parameter int InSigWidth = 25,
    parameter int ExpWidth   = 8,
    parameter int SigWidth   = 23
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  muntjac_fpu_pkg::rounding_mode_e  rounding_mode_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic                             sign_i,
    input  logic signed [InExpWidth-1:0]     exponent_i,
    input  logic [InSigWidth-1:0]            significand_i,
    input  logic                             is_zero_i,
    input  logic                             is_inf_i,
    input  logic                             is_nan_i,
    input  logic                             invalid_operation_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [ExpWidth+SigWidth:0]       data_o,
    output logic [4:0]                       flags_o
);
    import muntjac_fpu_pkg::*;

    localparam int BeWidth  = InExpWidth + 1;
    localparam int FieldW   = ExpWidth + SigWidth;
    localparam int StickyW  = InSigWidth - SigWidth - 1;
    localparam int ShiftMax = SigWidth + 2;
    localparam int ExtW     = InSigWidth + ShiftMax;
    localparam logic signed [BeWidth-1:0] Bias  = BeWidth'((2 ** (ExpWidth - 1)) - 1);
    localparam logic [BeWidth-1:0]        BeOvf = BeWidth'((2 ** ExpWidth) - 1);

    function automatic logic f_round_inc(input rounding_mode_e rm, input logic sign,
                                         input logic lsb, input logic g, input logic s);
        case (rm)
            RoundTiesToEven:     return g & (s | lsb);
            RoundTowardZero:     return 1'b0;
            RoundTowardNegative: return sign & (g | s);
            RoundTowardPositive: return ~sign & (g | s);
            RoundTiesToAway:     return g;
            default:             return 1'b0;
        endcase
    endfunction

    logic                     r_s1_valid;
    logic                     r_s1_sign;
    rounding_mode_e           r_s1_rm;
    logic [ExpWidth-1:0]      r_s1_exp;
    logic [SigWidth-1:0]      r_s1_frac;
    logic                     r_s1_g;
    logic                     r_s1_s;
    logic                     r_s1_tiny;
    logic                     r_s1_ovf;
    logic                     r_s1_nan;
    logic                     r_s1_inf;
    logic                     r_s1_zero;
    logic                     r_s1_nv;

    logic                     r_s2_valid;
    logic [FieldW:0]          r_s2_data;
    logic [4:0]               r_s2_flags;

    logic                     w_s1_advance;
    logic                     w_accept;

    // Stage 1: bias the exponent and denormalise when the result is below the normal range
    logic signed [BeWidth-1:0] w_be;
    logic                      w_be_neg;
    logic                      w_be_zero;
    logic                      w_be_pos;
    logic                      w_ovf_pre;
    logic [BeWidth-1:0]        w_shamt_raw;
    logic [BeWidth-1:0]        w_shamt;
    logic [ExtW-1:0]           w_ext;
    logic [SigWidth-1:0]       w_n_frac;
    logic                      w_n_g;
    logic                      w_n_s;
    logic [SigWidth-1:0]       w_d_frac;
    logic                      w_d_g;
    logic                      w_d_s;
    logic                      w_carry_n;
    logic                      w_tiny;
    logic [ExpWidth-1:0]       w_exp_field;
    logic [SigWidth-1:0]       w_frac;
    logic                      w_g;
    logic                      w_s;

    assign w_be        = {exponent_i[InExpWidth-1], exponent_i} + Bias;
    assign w_be_neg    = w_be[BeWidth-1];
    assign w_be_zero   = (w_be == '0);
    assign w_be_pos    = !w_be_neg && !w_be_zero;
    assign w_ovf_pre   = !w_be_neg && ($unsigned(w_be) >= BeOvf);

    assign w_shamt_raw = BeWidth'(1) - $unsigned(w_be);
    assign w_shamt     = (w_shamt_raw > BeWidth'(ShiftMax)) ? BeWidth'(ShiftMax) : w_shamt_raw;

    // Shift is always >= 1 on this path, so the hidden-bit slot is dropped by the truncation
    assign w_ext       = ExtW'({1'b1, significand_i, {ShiftMax{1'b0}}} >> w_shamt);

    assign w_n_frac    = significand_i[InSigWidth-1 -: SigWidth];
    assign w_n_g       = significand_i[StickyW];
    assign w_n_s       = |significand_i[StickyW-1:0];

    assign w_d_frac    = w_ext[ExtW-1 -: SigWidth];
    assign w_d_g       = w_ext[ExtW-SigWidth-1];
    assign w_d_s       = |w_ext[ExtW-SigWidth-2:0];

    // Tininess after rounding: would the unbounded-exponent result still sit below 2^emin?
    assign w_carry_n   = (&w_n_frac) &
                         f_round_inc(rounding_mode_i, sign_i, w_n_frac[0], w_n_g, w_n_s);
    assign w_tiny      = w_be_neg | (w_be_zero & !w_carry_n);

    assign w_exp_field = w_be_pos ? w_be[ExpWidth-1:0] : '0;
    assign w_frac      = w_be_pos ? w_n_frac : w_d_frac;
    assign w_g         = w_be_pos ? w_n_g    : w_d_g;
    assign w_s         = w_be_pos ? w_n_s    : w_d_s;

    assign w_s1_advance = !r_s2_valid | out_ready_i;
    assign in_ready_o   = !r_s1_valid | w_s1_advance;
    assign w_accept     = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_rm    <= RoundTiesToEven;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_g     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_tiny  <= 1'b0;
            r_s1_ovf   <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nv    <= 1'b0;
        end else begin
            if (in_ready_o) begin
                r_s1_valid <= in_valid_i;
            end
            if (w_accept) begin
                r_s1_sign <= sign_i;
                r_s1_rm   <= rounding_mode_i;
                r_s1_exp  <= w_exp_field;
                r_s1_frac <= w_frac;
                r_s1_g    <= w_g;
                r_s1_s    <= w_s;
                r_s1_tiny <= w_tiny;
                r_s1_ovf  <= w_ovf_pre;
                r_s1_nan  <= is_nan_i;
                r_s1_inf  <= is_inf_i;
                r_s1_zero <= is_zero_i;
                r_s1_nv   <= invalid_operation_i;
            end
        end
    end

    // Stage 2: increment {exponent, fraction} as one field so carries cross binades for free
    logic                w_inc;
    logic [FieldW-1:0]   w_sum;
    logic                w_ovf;
    logic                w_nx;
    logic                w_ovf_to_inf;
    logic [FieldW:0]     w_inf_word;
    logic [FieldW:0]     w_max_word;
    logic [FieldW:0]     w_data;
    logic [4:0]          w_flags;

    assign w_inc      = f_round_inc(r_s1_rm, r_s1_sign, r_s1_frac[0], r_s1_g, r_s1_s);
    assign w_sum      = {r_s1_exp, r_s1_frac} + FieldW'(w_inc);
    assign w_ovf      = r_s1_ovf | (&w_sum[FieldW-1:SigWidth]);
    assign w_nx       = r_s1_g | r_s1_s | w_ovf;
    assign w_inf_word = {r_s1_sign, {ExpWidth{1'b1}}, {SigWidth{1'b0}}};
    assign w_max_word = {r_s1_sign, {(ExpWidth-1){1'b1}}, 1'b0, {SigWidth{1'b1}}};

    always_comb begin
        w_ovf_to_inf = 1'b1;
        case (r_s1_rm)
            RoundTowardZero:     w_ovf_to_inf = 1'b0;
            RoundTowardNegative: w_ovf_to_inf = r_s1_sign;
            RoundTowardPositive: w_ovf_to_inf = !r_s1_sign;
            default:             w_ovf_to_inf = 1'b1;
        endcase
    end

    always_comb begin
        w_data  = {r_s1_sign, w_sum};
        w_flags = {r_s1_nv, 1'b0, 1'b0, r_s1_tiny & w_nx, w_nx};
        if (r_s1_nan) begin
            w_data  = {1'b0, {ExpWidth{1'b1}}, 1'b1, {(SigWidth-1){1'b0}}};
            w_flags = {r_s1_nv, 4'b0000};
        end else if (r_s1_inf) begin
            w_data  = w_inf_word;
            w_flags = {r_s1_nv, 4'b0000};
        end else if (r_s1_zero) begin
            w_data  = {r_s1_sign, {FieldW{1'b0}}};
            w_flags = {r_s1_nv, 4'b0000};
        end else if (w_ovf) begin
            w_data  = w_ovf_to_inf ? w_inf_word : w_max_word;
            w_flags = {r_s1_nv, 1'b0, 1'b1, r_s1_tiny, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_flags <= '0;
        end else if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data  <= w_data;
                r_s2_flags <= w_flags;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign data_o      = r_s2_data;
    assign flags_o     = r_s2_flags;

endmodule
